// File: rtl/spi_pkg.sv
// Shared definitions for the synchronous SPI slave: FSM state encoding,
// SPI mode constants ({CPOL,CPHA}) and a ceiling-log2 helper.
// No logic, no latency, no backpressure.
package spi_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Ceiling log2; used to size bit_cnt (WORD_W >= 2 gives at least 1 bit).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one async input with rise/fall detection.
// Latency: STAGES clk to dout; rise/fall are combinational off dout vs one extra flop.
// No backpressure.
// Ports: clk, rst (sync, active-high), din (async) -> dout (synced level), rise, fall (1-cycle).
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave, fully in the clk domain: oversampled sclk/cs_n/mosi, all 4 modes, any width/bit order.
// Latency: rx_valid SYNC_STAGES+2 clk after the final sample edge at the pin.
// Backpressure: single-word TX holding buffer (tx_valid/tx_ready); FILL_WORD sent on underrun; RX never stalls.
// Ports: clk, rst (sync, active-high); sclk, cs_n, mosi (async in); miso, miso_oe (out);
//        tx_data/tx_valid/tx_ready (TX buffer); rx_data/rx_valid (RX word); busy; frame_abort.
// Optional macro SPI_SLAVE_UNDERRUN_EN adds underrun_clr (in) and sticky tx_underrun (out).
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int                WORD_W      = 8,
  parameter int                CPOL        = 1,
  parameter int                CPHA        = 1,
  parameter int                MSB_FIRST   = 1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] FILL_WORD   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_abort
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  input  logic              underrun_clr,
  output logic              tx_underrun
`endif
);

  localparam int   CNT_W    = clog2(WORD_W);
  localparam logic POL      = (CPOL != 0);
  localparam logic PHA      = (CPHA != 0);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(POL)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

  // Leading edge leaves the idle level, trailing edge returns to it.
  logic lead_edge, trail_edge, sample_edge, launch_edge;
  assign lead_edge   = POL ? sclk_fall : sclk_rise;
  assign trail_edge  = POL ? sclk_rise : sclk_fall;
  assign sample_edge = PHA ? trail_edge : lead_edge;
  assign launch_edge = PHA ? lead_edge : trail_edge;

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              miso_q, miso_d;
  logic              fresh_q, fresh_d;   // tx_shift holds a word whose bit 0 is not yet on miso
  logic              done_q, done_d;     // rx_shift holds a complete word this cycle
  logic              rx_valid_q, rx_valid_d;
  logic              abort_q, abort_d;
  logic              consume;
  logic [WORD_W-1:0] next_word;

  assign next_word = buf_full_q ? buf_q : FILL_WORD;

  function automatic logic head_bit(input logic [WORD_W-1:0] w);
    return (MSB_FIRST != 0) ? w[WORD_W-1] : w[0];
  endfunction

  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    fresh_d    = fresh_q;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    consume    = 1'b0;

    if (done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_SHIFT;
          tx_shift_d = next_word;
          consume    = 1'b1;
          bit_cnt_d  = '0;
          // CPHA=0 drives bit 0 now; CPHA=1 waits for the first leading edge.
          fresh_d    = PHA;
          if (!PHA) miso_d = head_bit(next_word);
        end
      end
      default: begin
        if (sample_edge) begin
          rx_shift_d = (MSB_FIRST != 0) ? {rx_shift_q[WORD_W-2:0], mosi_s}
                                        : {mosi_s, rx_shift_q[WORD_W-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (launch_edge) begin
          if (bit_cnt_q == '0) begin
            if (fresh_q) begin
              miso_d  = head_bit(tx_shift_q);
              fresh_d = 1'b0;
            end else begin
              // Word boundary: start the next word from the holding buffer.
              tx_shift_d = next_word;
              consume    = 1'b1;
              miso_d     = head_bit(next_word);
            end
          end else begin
            tx_shift_d = advance(tx_shift_q);
            miso_d     = head_bit(advance(tx_shift_q));
          end
        end
        if (cs_rise) begin
          state_d   = ST_IDLE;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          fresh_d   = 1'b0;
          // A final sample edge in the same cycle completes the word instead.
          if (bit_cnt_q != '0 && !(sample_edge && bit_cnt_q == LAST_BIT)) abort_d = 1'b1;
        end
      end
    endcase

    // A load coinciding with consumption is held; the consumed word is the old one.
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (consume) buf_full_d = 1'b0;
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      miso_q     <= 1'b0;
      fresh_q    <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      miso_q     <= miso_d;
      fresh_q    <= fresh_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (consume && !buf_full_q) underrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) underrun_q <= 1'b0;
    else     underrun_q <= underrun_d;
  end

  assign tx_underrun = underrun_q;
`endif

  assign miso        = miso_q;
  assign miso_oe     = (state_q == ST_SHIFT);
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_abort = abort_q;
  assign busy        = ~cs_s & ~rst;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench: two slaves (A: mode 3, 8-bit, MSB first, fill FF; B: mode 0, 16-bit, LSB first, fill 0000)
// driven by a behavioural SPI master; expected words come from the master's own word lists.
module tb_spi_slave_sync;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sclk_a = 1'b1, cs_n_a = 1'b1, mosi_a = 1'b0, tx_valid_a = 1'b0;
  logic [7:0] tx_data_a = '0;
  logic       miso_a, miso_oe_a, tx_ready_a, rx_valid_a, busy_a, frame_abort_a;
  logic [7:0] rx_data_a;

  logic        sclk_b = 1'b0, cs_n_b = 1'b1, mosi_b = 1'b0, tx_valid_b = 1'b0;
  logic [15:0] tx_data_b = '0;
  logic        miso_b, miso_oe_b, tx_ready_b, rx_valid_b, busy_b, frame_abort_b;
  logic [15:0] rx_data_b;

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_clr_a = 1'b0, underrun_clr_b = 1'b0;
  logic tx_underrun_a, tx_underrun_b;
`endif

  spi_slave_sync #(.WORD_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2),
                   .FILL_WORD(8'hFF)) u_dut_a (
    .clk(clk), .rst(rst), .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a),
    .miso(miso_a), .miso_oe(miso_oe_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
    .frame_abort(frame_abort_a)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .underrun_clr(underrun_clr_a), .tx_underrun(tx_underrun_a)
`endif
  );

  spi_slave_sync #(.WORD_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2),
                   .FILL_WORD(16'h0000)) u_dut_b (
    .clk(clk), .rst(rst), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b),
    .miso(miso_b), .miso_oe(miso_oe_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
    .frame_abort(frame_abort_b)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .underrun_clr(underrun_clr_b), .tx_underrun(tx_underrun_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Received-word log and abort pulse counts, collected continuously.
  logic [15:0] rxq_a[$];
  logic [15:0] rxq_b[$];
  int abort_cnt_a = 0;
  int abort_cnt_b = 0;

  always @(negedge clk) begin
    if (rx_valid_a)    rxq_a.push_back({8'h00, rx_data_a});
    if (rx_valid_b)    rxq_b.push_back(rx_data_b);
    if (frame_abort_a) abort_cnt_a++;
    if (frame_abort_b) abort_cnt_b++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic set_sclk(input int d, input logic v);
    if (d == 0) sclk_a = v; else sclk_b = v;
  endtask
  task automatic set_cs(input int d, input logic v);
    if (d == 0) cs_n_a = v; else cs_n_b = v;
  endtask
  task automatic set_mosi(input int d, input logic v);
    if (d == 0) mosi_a = v; else mosi_b = v;
  endtask
  task automatic set_tx(input int d, input logic v, input logic [15:0] w);
    if (d == 0) begin tx_valid_a = v; tx_data_a = w[7:0]; end
    else begin tx_valid_b = v; tx_data_b = w; end
  endtask
  function automatic logic get_miso(input int d);
    return (d == 0) ? miso_a : miso_b;
  endfunction
  function automatic logic get_ready(input int d);
    return (d == 0) ? tx_ready_a : tx_ready_b;
  endfunction

  // SPI master. Stops after stop_bits bits (cs_n left low) when stop_bits > 0.
  task automatic master_frame(input int d, input int nw, input logic [15:0] mw [4],
                              output logic [15:0] sw [4], input int stop_bits);
    int   ww, idx, nbits;
    logic cpol, cpha, msb;
    ww    = (d == 0) ? 8 : 16;
    cpol  = (d == 0);
    cpha  = (d == 0);
    msb   = (d == 0);
    nbits = 0;
    for (int k = 0; k < 4; k++) sw[k] = '0;
    set_cs(d, 1'b0);
    half();
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < ww; i++) begin
        if (stop_bits > 0 && nbits == stop_bits) return;
        idx = msb ? (ww - 1 - i) : i;
        if (!cpha) begin
          set_mosi(d, mw[w][idx]);
          half();
          set_sclk(d, ~cpol);
          sw[w][idx] = get_miso(d);
          half();
          set_sclk(d, cpol);
        end else begin
          set_sclk(d, ~cpol);
          set_mosi(d, mw[w][idx]);
          half();
          set_sclk(d, cpol);
          sw[w][idx] = get_miso(d);
          half();
        end
        nbits++;
      end
    end
    if (!cpha) half();
    set_cs(d, 1'b1);
    half();
    half();
  endtask

  // Offers n words in order, holding tx_valid high until each is taken.
  task automatic feed(input int d, input int n, input logic [15:0] w [4]);
    int   k, guard;
    logic hs;
    k = 0;
    guard = 0;
    @(negedge clk);
    set_tx(d, 1'b1, w[0]);
    while (k < n && guard < 4000) begin
      hs = get_ready(d);
      @(negedge clk);
      guard++;
      if (hs) begin
        k++;
        if (k < n) set_tx(d, 1'b1, w[k]);
      end
    end
    set_tx(d, 1'b0, '0);
    check("feed_accepted", k, n);
  endtask

  logic [15:0] mw [4];
  logic [15:0] fw [4];
  logic [15:0] sw [4];
  int base_a, base_b, ab0, nw;
  logic [7:0] prev_rx;

  initial begin
    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_miso_a", miso_a, 0);
    check("rst_miso_oe_a", miso_oe_a, 0);
    check("rst_rx_data_a", rx_data_a, 0);
    check("rst_rx_valid_a", rx_valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_abort_a", frame_abort_a, 0);
    check("rst_tx_ready_a", tx_ready_a, 1);
    check("rst_miso_oe_b", miso_oe_b, 0);
    check("rst_rx_data_b", rx_data_b, 0);
    check("rst_tx_ready_b", tx_ready_b, 1);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("rst_underrun_a", tx_underrun_a, 0);
`endif

    // ---------------- mode 3: A5 out, 3C in ----------------
    base_a = rxq_a.size();
    fw[0] = 16'h00A5;
    feed(0, 1, fw);
    check("m3_tx_ready_loaded", tx_ready_a, 0);
    mw[0] = 16'h003C;
    fork
      master_frame(0, 1, mw, sw, 0);
      begin
        repeat (6) @(negedge clk);
        check("m3_tx_ready_cs_fall", tx_ready_a, 1);
        check("m3_busy", busy_a, 1);
        check("m3_miso_oe", miso_oe_a, 1);
      end
    join
    check("m3_miso_word", sw[0], 16'h00A5);
    check("m3_rx_count", rxq_a.size() - base_a, 1);
    check("m3_rx_data", rx_data_a, 8'h3C);
    check("m3_idle_oe", miso_oe_a, 0);
    check("m3_idle_busy", busy_a, 0);

    // ---------------- mode 0, LSB first, 16-bit, two words ----------------
    base_b = rxq_b.size();
    fw[0] = 16'hCAFE; fw[1] = 16'h0F0F;
    mw[0] = 16'h1234; mw[1] = 16'hBEEF;
    fork
      feed(1, 2, fw);
      begin
        repeat (4) @(negedge clk);
        master_frame(1, 2, mw, sw, 0);
      end
    join
    check("m0_miso_w0", sw[0], 16'hCAFE);
    check("m0_miso_w1", sw[1], 16'h0F0F);
    check("m0_rx_count", rxq_b.size() - base_b, 2);
    if (rxq_b.size() >= base_b + 2) begin
      check("m0_rx_w0", rxq_b[base_b], 16'h1234);
      check("m0_rx_w1", rxq_b[base_b+1], 16'hBEEF);
    end
    check("m0_no_abort", abort_cnt_b, 0);

    // ---------------- abort after 5 of 8 bits ----------------
    base_a  = rxq_a.size();
    ab0     = abort_cnt_a;
    prev_rx = rx_data_a;
    fw[0] = 16'($urandom_range(0, 255));
    feed(0, 1, fw);
    mw[0] = 16'($urandom_range(0, 255));
    master_frame(0, 1, mw, sw, 5);
    set_cs(0, 1'b1);
    half(); half();
    check("ab_pulses", abort_cnt_a - ab0, 1);
    check("ab_no_rx", rxq_a.size() - base_a, 0);
    check("ab_rx_kept", rx_data_a, prev_rx);
    fw[0] = 16'($urandom_range(0, 255));
    feed(0, 1, fw);
    mw[0] = 16'($urandom_range(0, 255));
    master_frame(0, 1, mw, sw, 0);
    check("ab_next_miso", sw[0], fw[0]);
    check("ab_next_rx", rx_data_a, mw[0][7:0]);
    check("ab_next_count", rxq_a.size() - base_a, 1);

    // ---------------- empty buffer -> fill word ----------------
    mw[0] = 16'($urandom_range(1, 255));
    master_frame(0, 1, mw, sw, 0);
    check("fill_miso", sw[0], 16'h00FF);
    check("fill_rx", rx_data_a, mw[0][7:0]);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("underrun_set", tx_underrun_a, 1);
    repeat (5) @(negedge clk);
    check("underrun_sticky", tx_underrun_a, 1);
    underrun_clr_a = 1'b1;
    @(negedge clk);
    underrun_clr_a = 1'b0;
    check("underrun_clr", tx_underrun_a, 0);
`endif

    // ---------------- reset mid-frame at bit 3 ----------------
    fw[0] = 16'h0033;
    feed(0, 1, fw);
    mw[0] = 16'($urandom_range(0, 255));
    master_frame(0, 1, mw, sw, 3);
    check("mr_busy_before", busy_a, 1);
    @(negedge clk);
    rst = 1'b1;
    set_cs(0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    check("mr_miso", miso_a, 0);
    check("mr_miso_oe", miso_oe_a, 0);
    check("mr_rx_data", rx_data_a, 0);
    check("mr_rx_valid", rx_valid_a, 0);
    check("mr_busy", busy_a, 0);
    check("mr_abort", frame_abort_a, 0);
    check("mr_tx_ready", tx_ready_a, 1);
    repeat (10) @(negedge clk);
    check("mr_stays_idle", miso_oe_a, 0);
    base_a = rxq_a.size();
    fw[0] = 16'($urandom_range(0, 255));
    feed(0, 1, fw);
    mw[0] = 16'($urandom_range(0, 255));
    master_frame(0, 1, mw, sw, 0);
    check("mr_resume_miso", sw[0], fw[0]);
    check("mr_resume_rx", rx_data_a, mw[0][7:0]);
    check("mr_resume_count", rxq_a.size() - base_a, 1);

    // ---------------- back-to-back, 4 words, tx_valid held ----------------
    base_a = rxq_a.size();
    for (int k = 0; k < 4; k++) begin
      fw[k] = 16'($urandom_range(0, 255));
      mw[k] = 16'($urandom_range(0, 255));
    end
    fork
      feed(0, 4, fw);
      begin
        repeat (4) @(negedge clk);
        master_frame(0, 4, mw, sw, 0);
      end
    join
    for (int k = 0; k < 4; k++) check($sformatf("b2b_miso_w%0d", k), sw[k], fw[k]);
    check("b2b_rx_count", rxq_a.size() - base_a, 4);
    for (int k = 0; k < 4; k++)
      if (rxq_a.size() > base_a + k) check($sformatf("b2b_rx_w%0d", k), rxq_a[base_a+k], mw[k]);
    check("b2b_tx_ready_end", tx_ready_a, 1);

    // ---------------- randomized frames on both slaves ----------------
    for (int it = 0; it < 3; it++) begin
      base_a = rxq_a.size();
      nw = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        fw[k] = 16'($urandom_range(0, 255));
        mw[k] = 16'($urandom_range(0, 255));
      end
      fork
        feed(0, nw, fw);
        begin
          repeat (4) @(negedge clk);
          master_frame(0, nw, mw, sw, 0);
        end
      join
      check($sformatf("rnd_a%0d_count", it), rxq_a.size() - base_a, nw);
      for (int k = 0; k < nw; k++) begin
        check($sformatf("rnd_a%0d_miso%0d", it, k), sw[k], fw[k]);
        if (rxq_a.size() > base_a + k) check($sformatf("rnd_a%0d_rx%0d", it, k), rxq_a[base_a+k], mw[k]);
      end
    end
    for (int it = 0; it < 2; it++) begin
      base_b = rxq_b.size();
      nw = $urandom_range(1, 2);
      for (int k = 0; k < 4; k++) begin
        fw[k] = 16'($urandom);
        mw[k] = 16'($urandom);
      end
      fork
        feed(1, nw, fw);
        begin
          repeat (4) @(negedge clk);
          master_frame(1, nw, mw, sw, 0);
        end
      join
      check($sformatf("rnd_b%0d_count", it), rxq_b.size() - base_b, nw);
      for (int k = 0; k < nw; k++) begin
        check($sformatf("rnd_b%0d_miso%0d", it, k), sw[k], fw[k]);
        if (rxq_b.size() > base_b + k) check($sformatf("rnd_b%0d_rx%0d", it, k), rxq_b[base_b+k], mw[k]);
      end
    end
    check("final_abort_b", abort_cnt_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
